slv_guard_rst_ctrl: RTL

Reset-side responder for the subordinate guard. It consumes the guard's reset request, isolates and resets the guarded subordinate, and returns the reset-status handshake that clears the guard's request. It sits between the guard's reset_req/reset_clear pair and the subordinate's local reset, with a bounded retry and a sticky failure flag.

---
 rtl/slv_guard_rst_pkg.sv | 12 +
 rtl/slv_guard_rst_timer.sv | 22 ++
 rtl/slv_guard_rst_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/slv_guard_rst_pkg.sv
// slv_guard_rst_pkg: state encoding, constants and helpers for the subordinate reset controller
package slv_guard_rst_pkg;

    typedef enum logic [2:0] {IDLE, ISOLATE, ASSERT, RELEASE, DONE, WAIT_CLR, FAIL} rst_state_e;

    localparam int RstCntWidth = 8;

    function automatic int max3(input int a, input int b, input int c);
        return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
    endfunction

endpackage

// File: rtl/slv_guard_rst_timer.sv
// slv_guard_rst_timer: loadable down-counter that stops at zero and flags it
module slv_guard_rst_timer #(
    parameter int Width = 9
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load,
    input  logic [Width-1:0] load_val,
    input  logic             enable,
    output logic             zero
);

    logic [Width-1:0] cnt;

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (enable && cnt != '0) cnt <= cnt - 1'b1;

    assign zero = cnt == '0;

endmodule

// File: rtl/slv_guard_rst_ctrl.sv
// slv_guard_rst_ctrl: isolates, resets and re-admits the guarded subordinate with bounded retry.
// Define SLV_GUARD_RST_CTRL_CNT_EN to enable the saturating completed-reset counter on rst_cnt_o.
module slv_guard_rst_ctrl
    import slv_guard_rst_pkg::*;
#(
    parameter int IsoCycles  = 8,
    parameter int HoldCycles = 16,
    parameter int AckTimeout = 256,
    parameter int MaxRetries = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   rst_req_i,
    input  logic                   slv_ready_i,
    output logic                   isolate_o,
    output logic                   slv_rst_no,
    output logic                   rst_stat_o,
    output logic                   busy_o,
    output logic                   fail_o,
    output logic [RstCntWidth-1:0] rst_cnt_o
);

    localparam int TmrWidth = $clog2(max3(IsoCycles, HoldCycles, AckTimeout)) + 1;
    localparam int RtyWidth = $clog2(MaxRetries + 2);

    rst_state_e          state_q, state_d;
    logic [RtyWidth-1:0] rty_q, rty_d;
    logic                extra_q, extra_d;
    logic                pulse_d;
    logic                tmr_load, tmr_en, tmr_zero;
    logic [TmrWidth-1:0] tmr_val;

    slv_guard_rst_timer #(.Width(TmrWidth)) u_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load     (tmr_load),
        .load_val (tmr_val),
        .enable   (tmr_en),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        rty_d    = rty_q;
        extra_d  = extra_q;
        pulse_d  = 1'b0;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        tmr_val  = '0;
        case (state_q)
            IDLE: if (rst_req_i) begin
                state_d  = ISOLATE;
                tmr_load = 1'b1;
                tmr_val  = TmrWidth'(IsoCycles - 1);
            end
            ISOLATE: if (tmr_zero) begin
                state_d  = ASSERT;
                tmr_load = 1'b1;
                tmr_val  = TmrWidth'(HoldCycles - 1);
            end else tmr_en = 1'b1;
            ASSERT: if (tmr_zero) begin
                state_d  = RELEASE;
                tmr_load = 1'b1;
                tmr_val  = TmrWidth'(AckTimeout - 1);
            end else tmr_en = 1'b1;
            // Ack is checked first so it wins over a same-cycle timeout
            RELEASE: if (slv_ready_i) state_d = DONE;
            else if (!tmr_zero) tmr_en = 1'b1;
            else if (rty_q < RtyWidth'(MaxRetries)) begin
                rty_d    = rty_q + 1'b1;
                state_d  = ASSERT;
                tmr_load = 1'b1;
                tmr_val  = TmrWidth'(HoldCycles - 1);
            end else state_d = FAIL;
            DONE: begin
                state_d = WAIT_CLR;
                extra_d = 1'b0;
            end
            WAIT_CLR: begin
                rty_d = '0;
                if (!rst_req_i) state_d = IDLE;
                else if (!extra_q) begin
                    pulse_d = 1'b1;
                    extra_d = 1'b1;
                end
            end
            FAIL: ;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            state_q    <= IDLE;
            rty_q      <= '0;
            extra_q    <= 1'b0;
            isolate_o  <= 1'b0;
            slv_rst_no <= 1'b1;
            rst_stat_o <= 1'b0;
            busy_o     <= 1'b0;
            fail_o     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rty_q      <= rty_d;
            extra_q    <= extra_d;
            isolate_o  <= state_d != IDLE;
            slv_rst_no <= !(state_d == ASSERT || state_d == FAIL);
            rst_stat_o <= state_d == DONE || pulse_d;
            busy_o     <= state_d != IDLE;
            fail_o     <= fail_o || state_d == FAIL;
        end

`ifdef SLV_GUARD_RST_CTRL_CNT_EN
    logic [RstCntWidth-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) cnt_q <= '0;
        else if (state_d == DONE && state_q != DONE && cnt_q != '1) cnt_q <= cnt_q + 1'b1;

    assign rst_cnt_o = cnt_q;
`else
    assign rst_cnt_o = '0;
`endif

endmodule
